// File: rtl/dnn_event_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_event_capture_pkg
//  Description : Shared types and constants for the DUT result-pin event
//                capture stage: event word layout, FSM encoding and pin
//                indices inside the synchroniser vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package dnn_event_capture_pkg;

   // Width of the timestamp field inside an event word
   localparam int TS_MAX_WIDTH = 27;
   localparam int WORD_WIDTH   = 32;

   // Bit positions inside an event word
   localparam int BIT_MARKER = 31;
   localparam int BIT_UP     = 30;
   localparam int BIT_DN     = 29;
   localparam int BIT_DNN1   = 28;
   localparam int BIT_DNN0   = 27;

   // Pin order inside the synchroniser vector
   localparam int NUM_PINS = 4;
   localparam int PIN_DN   = 0;
   localparam int PIN_UP   = 1;
   localparam int PIN_DNN0 = 2;
   localparam int PIN_DNN1 = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic                    marker;
      logic                    up;
      logic                    dn;
      logic                    dnn1;
      logic                    dnn0;
      logic [TS_MAX_WIDTH-1:0] ts;
   } event_word_t;

endpackage
`default_nettype wire

// File: rtl/dnn_event_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : evt_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head word is
//                presented on o_pop_data whenever o_valid is high. A push
//                while full is accepted only if a pop happens in the same
//                cycle; otherwise it is dropped and flagged on o_drop.
//  Ports       : clk, rst (async, active-high), i_flush (sync empty),
//                i_push/i_push_data, i_pop, o_pop_data, o_valid, o_count,
//                o_full, o_push_ok (push accepted), o_drop (push dropped).
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_push_ok,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   // Pop while empty is ignored; a pop frees the slot a full push needs
   assign w_pop_ok  = i_pop && !w_empty;
   assign w_push_ok = i_push && (!w_full || w_pop_ok);

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: unread slots are never exposed
   always_ff @(posedge clk) begin
      if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_valid    = !w_empty;
   assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_full     = w_full;
   assign o_push_ok  = w_push_ok && !i_flush;
   assign o_drop     = i_push && !w_push_ok && !i_flush;

endmodule
`default_nettype wire

// File: rtl/dnn_event_capture.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_event_capture
//  Description : Synchronises the DUT result pins, converts dn/up toggle
//                transitions into timestamped 32-bit event words and queues
//                them in an FWFT FIFO drained by the AXI register block.
//  Ports       : S_AXI_ACLK, S_AXI_ARESET (async, active-high), enable,
//                clear, dn_event_toggle, up_event_toggle, dnn_output_0,
//                dnn_output_1, rd_en -> rd_data, rd_valid, fifo_count,
//                fifo_full, overflow_cnt, event_cnt, state.
//  Options     : `define DNN_EVENT_CAPTURE_WRAP_MARKER_EN to push a marker
//                word each time the running timestamp wraps to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dnn_event_capture
   import dnn_event_capture_pkg::*;
#(
   parameter int TS_WIDTH    = 24,
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic                          enable,
   input  logic                          clear,
   input  logic                          dn_event_toggle,
   input  logic                          up_event_toggle,
   input  logic                          dnn_output_0,
   input  logic                          dnn_output_1,
   input  logic                          rd_en,
   output logic [31:0]                   rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_full,
   output logic [15:0]                   overflow_cnt,
   output logic [31:0]                   event_cnt,
   output logic [1:0]                    state
);

   logic clk;
   logic rst;
   assign clk = S_AXI_ACLK;
   assign rst = S_AXI_ARESET;

   // ---------------------------------------------------------------- sync
   logic [NUM_PINS-1:0] w_pins;
   logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
   logic [NUM_PINS-1:0] w_synced;

   assign w_pins = {dnn_output_1, dnn_output_0, up_event_toggle, dn_event_toggle};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= w_pins;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

   // History always follows the synced toggles. That covers tracking in
   // IDLE, the reload in ARM and the reload on clear in RUN: a toggle is
   // only ever seen as an event in the first RUN cycle it appears in.
   logic [1:0] r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_hist <= '0;
      else     r_hist <= {w_synced[PIN_UP], w_synced[PIN_DN]};
   end

   // ----------------------------------------------------------------- FSM
   state_t r_state;
   state_t w_state_next;
   logic   w_run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (!clear) begin
         case (r_state)
            IDLE:    w_state_next = enable ? ARM : IDLE;
            ARM:     w_state_next = enable ? RUN : IDLE;
            RUN:     w_state_next = enable ? RUN : IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_run = (r_state == RUN);
      state = r_state;
   end

   // ----------------------------------------------------------- timestamp
   logic [TS_WIDTH-1:0] r_ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_ts <= '0;
      else if (clear)           r_ts <= '0;
      else if (w_run && enable) r_ts <= r_ts + 1'b1;
      else                      r_ts <= '0;
   end

   // ------------------------------------------------------ event building
   logic        w_dn_tgl;
   logic        w_up_tgl;
   logic        w_detect;
   logic        w_push;
   event_word_t w_word;

   assign w_dn_tgl = w_synced[PIN_DN] ^ r_hist[0];
   assign w_up_tgl = w_synced[PIN_UP] ^ r_hist[1];
   assign w_detect = w_run && (w_dn_tgl || w_up_tgl) && !clear;

`ifdef DNN_EVENT_CAPTURE_WRAP_MARKER_EN
   logic w_wrap;
   // The counter rolls to zero at the end of this cycle
   assign w_wrap = w_run && enable && !clear && (r_ts == {TS_WIDTH{1'b1}});
`endif

   always_comb begin
      w_word        = '0;
      w_word.up     = w_up_tgl;
      w_word.dn     = w_dn_tgl;
      w_word.dnn1   = w_synced[PIN_DNN1];
      w_word.dnn0   = w_synced[PIN_DNN0];
      w_word.ts     = TS_MAX_WIDTH'(r_ts);
      w_push        = w_detect;
`ifdef DNN_EVENT_CAPTURE_WRAP_MARKER_EN
      // One write port: a coincident toggle rides along in the marker
      if (w_wrap) begin
         w_word.marker = 1'b1;
         w_word.dnn1   = 1'b0;
         w_word.dnn0   = 1'b0;
         w_word.ts     = '0;
         w_push        = 1'b1;
      end
`endif
   end

   // One register stage between detection and the FIFO write port
   logic        r_push;
   event_word_t r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_push <= 1'b0;
         r_word <= '0;
      end else if (clear) begin
         r_push <= 1'b0;
         r_word <= '0;
      end else begin
         r_push <= w_push;
         r_word <= w_word;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic w_push_ok;
   logic w_drop;

   evt_sync_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (clear),
      .i_push      (r_push),
      .i_push_data (r_word),
      .i_pop       (rd_en),
      .o_pop_data  (rd_data),
      .o_valid     (rd_valid),
      .o_count     (fifo_count),
      .o_full      (fifo_full),
      .o_push_ok   (w_push_ok),
      .o_drop      (w_drop)
   );

   // ------------------------------------------------------------ counters
   logic [15:0] r_overflow_cnt;
   logic [31:0] r_event_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow_cnt <= '0;
         r_event_cnt    <= '0;
      end else if (clear) begin
         r_overflow_cnt <= '0;
         r_event_cnt    <= '0;
      end else begin
         if (w_push_ok) r_event_cnt <= r_event_cnt + 1'b1;
         if (w_drop && (r_overflow_cnt != 16'hFFFF))
            r_overflow_cnt <= r_overflow_cnt + 1'b1;
      end
   end

   assign overflow_cnt = r_overflow_cnt;
   assign event_cnt    = r_event_cnt;

endmodule
`default_nettype wire
